lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store control unit placed directly upstream of the data memory: accepts one load or store request from the core, issues word-wide accesses to data memory, and returns a response. Byte/halfword stores are performed as read-modify-write, because data memory always writes whole 32-bit words. Byte/halfword loads have lane extraction and sign/zero extension done here. Misaligned and out-of-range accesses are rejected with an error response and never reach memory.

## Interface
- ADDR_W, 10, valid byte-address bits (256 words); any set bit in req_addr[31:ADDR_W] is an error
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; request accepted on edge where req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 illegal
- req_unsigned  in  1  load zero-extend (1) / sign-extend (0); ignored for stores and words
- req_addr  in  32  byte address
- req_wdata  in  32  store data, lane-0 aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  one-cycle pulse, response complete; no backpressure
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  valid with rsp_valid; misaligned/illegal/out-of-range
- mem_memi  out  5  data-memory control: [4] unsigned, [3:2] size, [1] write, [0] read
- mem_addr  out  32  {addr[31:2], 2'b00} of latched request
- mem_data  out  32  full word to write
- mem_wren  out  1  data-memory write enable
- mem_rdata  in  32  asynchronous word read data from data memory

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On accept, latch we/size/unsigned/addr/wdata. Error check: size==3; size==1 && addr[0]; size==2 && addr[1:0]!=0; addr[31:ADDR_W]!=0. Error -> RESP with err=1. Load or sub-word store -> READ. Word store -> WRITE.
- READ: mem_memi=5'b11001 (unsigned, word, read). Capture mem_rdata at the end of the cycle. Load -> RESP with extracted data. Sub-word store -> WRITE with merged word.
- WRITE: mem_memi=5'b11010, mem_wren = rst_n (a write is suppressed in any cycle where rst_n is low). mem_data = store word (word store) or merged word. -> RESP.
- RESP: rsp_valid=1, rsp_err and rsp_rdata held from registers. -> IDLE.
- Other states/outside access: mem_memi=0, mem_wren=0, mem_data=0.
- Lanes are little-endian. Byte lane k=addr[1:0] occupies [8k+7:8k]. Half lane h=addr[1] occupies [16h+15:16h].
- Load extract: shift the selected lane to [7:0]/[15:0], then extend per req_unsigned. Word loads pass through unchanged.
- Merge: replace only the selected lane of the captured word with req_wdata[7:0]/[15:0]. All other bits keep their read values.
- Reset (rst_n low at an edge): state -> IDLE. rsp_valid=0, rsp_err=0, rsp_rdata=0, internal latches 0. Any in-flight operation is aborted with no response.

## Timing
- Accept at edge T.
- Error: rsp_valid during T+1.
- Load: READ in T+1, rsp_valid in T+2.
- Word store: WRITE in T+1 (memory updated at edge ending T+1), rsp_valid in T+2.
- Sub-word store: READ in T+1, WRITE in T+2, rsp_valid in T+3.
- req_ready=0 from T+1 until return to IDLE, so the next accept is no earlier than the cycle after RESP.
- Reset values of all outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_memi=0, mem_wren=0, mem_data=0, mem_addr=0.

## Test plan
- Word store then load: store 0xDEADBEEF at 0x10, then load word at 0x10. Write occurs with mem_data=0xDEADBEEF; load response arrives 2 cycles after accept with rsp_rdata=0xDEADBEEF, err=0.
- Byte RMW: word 0x11223344 at 0x20, store byte 0xAA at 0x22. Memory becomes 0x11AA3344; rsp 3 cycles after accept.
- Extension: memory 0x80FF7F01 at 0x30. Expected loads:
  - signed byte @0x32 -> 0xFFFFFFFF
  - unsigned byte @0x32 -> 0x000000FF
  - signed half @0x32 -> 0xFFFF80FF
  - unsigned half @0x30 -> 0x00007F01
- Errors: half @0x31, word @0x22, size=3, addr 0x400. Each gives rsp_valid at T+1 with err=1, rdata=0; mem_memi stays 0 throughout.
- Reset mid-op: drop rst_n during the WRITE cycle of a byte store. Memory word is unchanged, no rsp_valid, state returns to IDLE, req_ready=1 on the next cycle.
- Backpressure: hold req_valid high continuously. Exactly one accept per operation; req_ready low in READ/WRITE/RESP; second accept occurs in the IDLE cycle after the response.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store control unit in front of a word-wide data memory.
// Sub-word stores are read-modify-write; sub-word loads are lane-extracted and extended here.
module lsu_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [4:0]  mem_memi,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_wren,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_reg;
    logic        we_reg;
    logic [1:0]  size_reg;
    logic        uns_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;

    logic        req_err;
    logic [7:0]  lane [4];
    logic [3:0]  lane_sel;
    logic [31:0] merged;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_data;

    always_comb begin
        req_err = (req_size == 2'd3)
               || (req_size == 2'd1 && req_addr[0])
               || (req_size == 2'd2 && req_addr[1:0] != 2'd0)
               || (|req_addr[31:ADDR_W]);
    end

    // Per-byte lane view of the read word; selected lanes take store data, the rest keep memory data.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi]     = mem_rdata[8*gi +: 8];
        assign lane_sel[gi] = (size_reg == 2'd0) ? (addr_reg[1:0] == 2'(gi))
                                                 : (addr_reg[1] == 1'(gi / 2));
        assign merged[8*gi +: 8] = !lane_sel[gi]     ? lane[gi] :
                                   (size_reg == 2'd0) ? wdata_reg[7:0]
                                                      : wdata_reg[8*(gi % 2) +: 8];
    end

    assign byte_val = lane[addr_reg[1:0]];
    assign half_val = addr_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        case (size_reg)
            2'd0:    load_data = {{24{!uns_reg && byte_val[7]}}, byte_val};
            2'd1:    load_data = {{16{!uns_reg && half_val[15]}}, half_val};
            default: load_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            we_reg    <= 1'b0;
            size_reg  <= 2'd0;
            uns_reg   <= 1'b0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            rdata_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        we_reg    <= req_we;
                        size_reg  <= req_size;
                        uns_reg   <= req_unsigned;
                        addr_reg  <= req_addr;
                        wdata_reg <= req_wdata;
                        rdata_reg <= 32'd0;
                        err_reg   <= req_err;
                        if (req_err)
                            state_reg <= RESP;
                        else if (!req_we || req_size != 2'd2)
                            state_reg <= READ;
                        else
                            state_reg <= WRITE;
                    end
                end
                READ: begin
                    // Sub-word stores reuse the store-data register to hold the merged word.
                    if (we_reg) begin
                        wdata_reg <= merged;
                        state_reg <= WRITE;
                    end else begin
                        rdata_reg <= load_data;
                        state_reg <= RESP;
                    end
                end
                WRITE:   state_reg <= RESP;
                RESP:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign rsp_rdata = rdata_reg;
    assign rsp_err   = err_reg;
    assign mem_addr  = {addr_reg[31:2], 2'b00};
    assign mem_memi  = (state_reg == READ)  ? 5'b11001 :
                       (state_reg == WRITE) ? 5'b11010 : 5'b00000;
    assign mem_wren  = (state_reg == WRITE) && rst_n;
    assign mem_data  = (state_reg == WRITE) ? wdata_reg : 32'd0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: word memory model, cycle-level expectation model and directed requests.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [4:0]  mem_memi;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_memi(mem_memi), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_wren(mem_wren), .mem_rdata(mem_rdata)
    );

    logic [31:0] env_mem [256];
    logic [31:0] ref_mem [256];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Model of the single in-flight operation (cycle numbers, -1 = none)
    int op_acc = -100, op_rd = -1, op_wr = -1, op_rsp = -1;
    logic        exp_err;
    logic [31:0] exp_rdata, exp_wword, exp_maddr;
    int acc_count = 0, rsp_count = 0, last_acc = -1, last_rsp = -1;
    logic [31:0] last_rdata;
    logic        last_err;

    assign mem_rdata = env_mem[mem_addr[9:2]];

    function automatic logic [31:0] init_word(int i);
        case (i)
            8:       return 32'h11223344;
            12:      return 32'h80FF7F01;
            16:      return 32'h55667788;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic [31:0] model_load(logic [31:0] word, logic [1:0] size, logic uns, logic [31:0] addr);
        logic [31:0] v;
        int k;
        k = int'(addr[1:0]);
        if (size == 2'd0) begin
            v = (word >> (8 * k)) & 32'hFF;
            if (!uns && v >= 32'd128) v = v + 32'hFFFFFF00;
        end else if (size == 2'd1) begin
            v = (word >> (16 * int'(addr[1]))) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_merge(logic [31:0] word, logic [1:0] size, logic [31:0] addr, logic [31:0] wdata);
        logic [31:0] mask;
        int k;
        if (size == 2'd2) return wdata;
        k = int'(addr[1:0]);
        mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * k);
        return (word & ~mask) | ((wdata << (8 * k)) & mask);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 256; i++) env_mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_wren) env_mem[mem_addr[9:2]] <= mem_data;
        end
    end

    // Compare process: every cycle, DUT outputs against the model, then advance the model.
    initial begin
        int c;
        bit busy, exp_ready, err;
        logic [31:0] word;
        logic [4:0] exp_memi;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (chk_en) begin
                c = cyc;
                busy = (c > op_acc) && (c <= op_rsp);
                exp_ready = !busy;
                check32("req_ready", 32'(req_ready), 32'(exp_ready));
                check32("rsp_valid", 32'(rsp_valid), 32'(c == op_rsp));
                if (c == op_rsp) begin
                    check32("rsp_err", 32'(rsp_err), 32'(exp_err));
                    check32("rsp_rdata", rsp_rdata, exp_rdata);
                    last_rdata = rsp_rdata;
                    last_err = rsp_err;
                    last_rsp = c;
                    rsp_count++;
                end
                exp_memi = (c == op_rd) ? 5'b11001 : (c == op_wr) ? 5'b11010 : 5'b00000;
                check32("mem_memi", 32'(mem_memi), 32'(exp_memi));
                check32("mem_wren", 32'(mem_wren), 32'((c == op_wr) && rst_n));
                check32("mem_data", mem_data, (c == op_wr) ? exp_wword : 32'd0);
                if (c == op_rd || c == op_wr) check32("mem_addr", mem_addr, exp_maddr);
                if (c == op_wr && rst_n) ref_mem[exp_maddr[9:2]] = exp_wword;
                if (!rst_n) begin
                    op_acc = -100; op_rd = -1; op_wr = -1; op_rsp = -1;
                end else if (req_valid && exp_ready) begin
                    err = (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0])
                       || (req_size == 2'd2 && req_addr[1:0] != 2'd0) || (req_addr >= 32'd1024);
                    op_acc = c;
                    acc_count++;
                    last_acc = c;
                    exp_maddr = req_addr & ~32'd3;
                    word = ref_mem[req_addr[9:2]];
                    exp_rdata = 32'd0;
                    exp_err = err;
                    if (err) begin
                        op_rd = -1; op_wr = -1; op_rsp = c + 1;
                    end else if (!req_we) begin
                        op_rd = c + 1; op_wr = -1; op_rsp = c + 2;
                        exp_rdata = model_load(word, req_size, req_unsigned, req_addr);
                    end else if (req_size == 2'd2) begin
                        op_rd = -1; op_wr = c + 1; op_rsp = c + 2;
                        exp_wword = req_wdata;
                    end else begin
                        op_rd = c + 1; op_wr = c + 2; op_rsp = c + 3;
                        exp_wword = model_merge(word, req_size, req_addr, req_wdata);
                    end
                end
            end
        end
    end

    task automatic run_op(input string name, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int lat,
                          input logic [31:0] lit_rdata, input logic lit_err);
        bit got;
        @(posedge clk); #1;
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin got = 1'b1; break; end
        end
        if (!got) timeout_fail({name, " accept"});
        @(posedge clk); #1;
        req_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) begin got = 1'b1; break; end
        end
        #1;
        if (!got) timeout_fail({name, " rsp"});
        else begin
            check32({name, " latency"}, 32'(last_rsp - last_acc), 32'(lat));
            check32({name, " rdata"}, last_rdata, lit_rdata);
            check32({name, " err"}, 32'(last_err), 32'(lit_err));
        end
    endtask

    initial begin
        int n, a1, a2, acc0, rsp0;
        bit got;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk); #1;
        check32("reset req_ready", 32'(req_ready), 32'd1);
        check32("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check32("reset rsp_rdata", rsp_rdata, 32'd0);
        check32("reset rsp_err", 32'(rsp_err), 32'd0);
        check32("reset mem_memi", 32'(mem_memi), 32'd0);
        check32("reset mem_wren", 32'(mem_wren), 32'd0);
        check32("reset mem_data", mem_data, 32'd0);
        check32("reset mem_addr", mem_addr, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op("st_word",   1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0);
        check32("mem@10", env_mem[4], 32'hDEADBEEF);
        run_op("ld_word",   1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0);
        run_op("st_byte",   1'b1, 2'd0, 1'b0, 32'h22, 32'h55AA, 3, 32'h0, 1'b0);
        check32("mem@20", env_mem[8], 32'h11AA3344);
        run_op("ld_sb32",   1'b0, 2'd0, 1'b0, 32'h32, 32'h0, 2, 32'hFFFFFFFF, 1'b0);
        run_op("ld_ub32",   1'b0, 2'd0, 1'b1, 32'h32, 32'h0, 2, 32'h000000FF, 1'b0);
        run_op("ld_sh32",   1'b0, 2'd1, 1'b0, 32'h32, 32'h0, 2, 32'hFFFF80FF, 1'b0);
        run_op("ld_uh30",   1'b0, 2'd1, 1'b1, 32'h30, 32'h0, 2, 32'h00007F01, 1'b0);
        run_op("ld_sb31",   1'b0, 2'd0, 1'b0, 32'h31, 32'h0, 2, 32'h0000007F, 1'b0);
        run_op("st_half",   1'b1, 2'd1, 1'b0, 32'h32, 32'hABCD1234, 3, 32'h0, 1'b0);
        check32("mem@30", env_mem[12], 32'h12347F01);
        run_op("ld_word30", 1'b0, 2'd2, 1'b1, 32'h30, 32'h0, 2, 32'h12347F01, 1'b0);
        run_op("err_half",  1'b0, 2'd1, 1'b0, 32'h31, 32'h0, 1, 32'h0, 1'b1);
        run_op("err_word",  1'b0, 2'd2, 1'b0, 32'h22, 32'h0, 1, 32'h0, 1'b1);
        run_op("err_size3", 1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 1, 32'h0, 1'b1);
        run_op("err_range", 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 1, 32'h0, 1'b1);
        run_op("err_st",    1'b1, 2'd2, 1'b0, 32'h412, 32'h0, 1, 32'h0, 1'b1);
        check32("mem@10 kept", env_mem[4], 32'hDEADBEEF);

        // Reset asserted during the WRITE cycle of a byte store
        rsp0 = rsp_count;
        @(posedge clk); #1;
        req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h41; req_wdata = 32'h99;
        req_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin got = 1'b1; break; end
        end
        if (!got) timeout_fail("rst_mid accept");
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check32("rst_mid req_ready", 32'(req_ready), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        check32("rst_mid no rsp", 32'(rsp_count - rsp0), 32'd0);
        check32("rst_mid mem@40", env_mem[16], 32'h55667788);

        // Backpressure: request held high across two operations
        acc0 = acc_count;
        n = 0; a1 = 0; a2 = 0;
        @(posedge clk); #1;
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h20; req_wdata = 32'h0;
        req_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (req_ready) begin
                n++;
                if (n == 1) a1 = cyc;
                if (n == 2) begin a2 = cyc; break; end
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) begin got = 1'b1; break; end
        end
        #1;
        if (n != 2 || !got) timeout_fail("backpressure");
        check32("bp accept spacing", 32'(a2 - a1), 32'd3);
        check32("bp accept count", 32'(acc_count - acc0), 32'd2);
        check32("bp rdata", last_rdata, 32'h11AA3344);

        repeat (2) @(negedge clk);
        n = 0;
        for (int i = 0; i < 256; i++) if (env_mem[i] !== ref_mem[i]) n++;
        check32("final mem mismatches", 32'(n), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
